// File: rtl/mix_column_engine.sv
// ============================================================================
// Module   : mix_column_engine
// Brief    : Iterative handshaked AES MixColumns / InvMixColumns / bypass,
//            COLS_PER_CYCLE columns transformed per clock.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mix_column_engine #(
    parameter int COLS_PER_CYCLE = 1,
    parameter int NB             = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [1:0]   mode_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         mode_err
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
        if (NB != 4) begin : g_bad_nb
            $error("mix_column_engine: NB must be 4");
        end
    endgenerate

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic [1:0]   r_col_cnt;
    logic [1:0]   r_mode;
    logic [127:0] r_work;
    logic [127:0] w_work_next;
    logic         r_mode_err;
    logic [2:0]   w_cnt_sum;
    logic         w_last;
    logic         w_accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficients 0e/0b/0d/09 are composed from the x2/x4/x8 chains only.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] res;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            if (inv) begin
                res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                                 ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                                 ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                                 ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
            end else begin
                res[31-8*r -: 8] = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4]
                                 ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
        return res;
    endfunction

    assign w_accept  = (r_state == c_idle) && in_valid;
    assign w_cnt_sum = {1'b0, r_col_cnt} + 3'(COLS_PER_CYCLE);
    assign w_last    = (w_cnt_sum == 3'(NB));

    // Every column has its own mixer; only the active group is written back.
    generate
        for (genvar c = 0; c < 4; c++) begin : g_col
            logic [31:0] w_col;
            logic [31:0] w_mixed;
            logic        w_sel;

            assign w_col = r_work[127-32*c -: 32];
            assign w_sel = (r_col_cnt == 2'((c / COLS_PER_CYCLE) * COLS_PER_CYCLE));

            always_comb begin
                w_mixed = w_col;
                if (r_mode == 2'b00) begin
                    w_mixed = mix_col(w_col, 1'b0);
                end else if (r_mode == 2'b01) begin
                    w_mixed = mix_col(w_col, 1'b1);
                end
            end

            assign w_work_next[127-32*c -: 32] = w_sel ? w_mixed : w_col;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (in_valid)  w_next_state = c_busy;
            c_busy:  if (w_last)    w_next_state = c_done;
            c_done:  if (out_ready) w_next_state = c_idle;
            default:                w_next_state = c_idle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_idle);
        out_valid = (r_state == c_done);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_work     <= '0;
            r_mode     <= 2'b00;
            r_col_cnt  <= 2'd0;
            r_mode_err <= 1'b0;
        end else if (w_accept) begin
            r_work    <= state_in;
            r_mode    <= mode_in;
            r_col_cnt <= 2'd0;
            if (mode_in == 2'b11) begin
                r_mode_err <= 1'b1;
            end
        end else if (r_state == c_busy) begin
            r_work    <= w_work_next;
            r_col_cnt <= w_cnt_sum[1:0];
        end
    end

    assign state_out = r_work;
    assign mode_err  = r_mode_err;

endmodule

`default_nettype wire

// File: tb/tb_mix_column_engine.sv
// ============================================================================
// Module   : tb_mix_column_engine
// Brief    : Self-checking bench; three engines (1, 2, 4 columns per cycle)
//            run side by side against a GF(2^8) matrix reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mix_column_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] state_in;
    logic [1:0]   mode_in;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic void check(input string name, input int cpc,
                                  input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cpc=%0d): got %h expected %h", name, cpc, act, exp);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product per column; modes 2 and 3 pass through.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic [1:0] m);
        logic [7:0]   co [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (m >= 2'd2) return s;
        if (m == 2'd0) co = '{8'h02, 8'h03, 8'h01, 8'h01};
        else           co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        r = s;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(co[k], s[127-8*(4*c+(row+k)%4) -: 8]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_inst
            localparam int CPC = 1 << g;
            logic         in_ready_w;
            logic         out_valid_w;
            logic         mode_err_w;
            logic [127:0] dut_out;
            int           phase   = 0;   // 0 waiting, 1 computing, 2 holding result
            int           cnt     = 0;
            logic [127:0] exp_out = '0;
            logic         exp_err = 1'b0;
            logic         fresh   = 1'b1;
            logic [127:0] last_out = '0;

            mix_column_engine #(.COLS_PER_CYCLE(CPC), .NB(4)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (in_ready_w),
                .state_in  (state_in),
                .mode_in   (mode_in),
                .out_valid (out_valid_w),
                .out_ready (out_ready),
                .state_out (dut_out),
                .mode_err  (mode_err_w)
            );

            always @(posedge clk) begin
                if (!rst_n) begin
                    phase = 0; fresh = 1'b1; exp_err = 1'b0;
                end else if (phase == 0) begin
                    if (in_valid) begin
                        phase   = 1;
                        cnt     = 4 / CPC;
                        exp_out = ref_mix(state_in, mode_in);
                        fresh   = 1'b0;
                        if (mode_in == 2'b11) exp_err = 1'b1;
                    end
                end else if (phase == 1) begin
                    cnt = cnt - 1;
                    if (cnt == 0) phase = 2;
                end else if (out_ready) begin
                    phase = 0;
                end
            end

            always @(negedge clk) begin
                check("in_ready",  CPC, 128'(in_ready_w),  128'(phase == 0));
                check("out_valid", CPC, 128'(out_valid_w), 128'(phase == 2));
                check("mode_err",  CPC, 128'(mode_err_w),  128'(exp_err));
                if (phase == 2)  check("state_out", CPC, dut_out, exp_out);
                else if (fresh)  check("state_out_reset", CPC, dut_out, 128'd0);
                if (out_valid_w && out_ready) last_out = dut_out;
            end
        end
    endgenerate

    function automatic bit all_phase(input int p);
        return g_inst[0].phase == p && g_inst[1].phase == p && g_inst[2].phase == p;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_idle(input bit rnd_ready);
        for (int i = 0; i < 300; i++) begin
            if (all_phase(0)) break;
            if (rnd_ready) out_ready = 1'($urandom % 2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("idle_timeout", 0, 128'(all_phase(0)), 128'd1);
    endtask

    task automatic send(input logic [127:0] s, input logic [1:0] m, input bit rnd_ready);
        in_valid = 1'b1; state_in = s; mode_in = m;
        @(posedge clk); #1;
        in_valid = 1'b0; state_in = rnd128(); mode_in = 2'($urandom % 4);
        wait_idle(rnd_ready);
    endtask

    task automatic check_last(input string name, input logic [127:0] exp);
        check(name, 1, g_inst[0].last_out, exp);
        check(name, 2, g_inst[1].last_out, exp);
        check(name, 4, g_inst[2].last_out, exp);
    endtask

    task automatic check_err(input string name, input logic exp);
        check(name, 1, 128'(g_inst[0].mode_err_w), 128'(exp));
        check(name, 2, 128'(g_inst[1].mode_err_w), 128'(exp));
        check(name, 4, 128'(g_inst[2].mode_err_w), 128'(exp));
    endtask

    localparam logic [127:0] c_fips_in  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] c_fips_out = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] c_col_in   = {4{32'hdb135345}};
    localparam logic [127:0] c_col_out  = {4{32'h8e4da1bc}};
    localparam logic [127:0] c_seq      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_c6       = {16{8'hc6}};

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        state_in = rnd128(); mode_in = 2'b00;

        check("model_fwd", 0, ref_mix(c_fips_in, 2'b00), c_fips_out);
        check("model_inv", 0, ref_mix(c_fips_out, 2'b01), c_fips_in);
        check("model_col_fwd", 0, ref_mix(c_col_in, 2'b00), c_col_out);
        check("model_col_inv", 0, ref_mix(c_col_out, 2'b01), c_col_in);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b0;

        send(c_fips_in, 2'b00, 1'b0);  check_last("fips_fwd", c_fips_out);
        send(c_fips_out, 2'b01, 1'b0); check_last("fips_inv", c_fips_in);
        send(c_col_in, 2'b00, 1'b0);   check_last("col_fwd", c_col_out);
        send(c_col_out, 2'b01, 1'b0);  check_last("col_inv", c_col_in);

        send(c_seq, 2'b10, 1'b0);      check_last("bypass", c_seq);   check_err("err_after_bypass", 1'b0);
        send(c_seq, 2'b11, 1'b0);      check_last("reserved", c_seq); check_err("err_after_reserved", 1'b1);
        send(c_fips_in, 2'b00, 1'b0);  check_err("err_sticky", 1'b1);

        // Hold the result while a competing request is presented.
        out_ready = 1'b0; in_valid = 1'b1; state_in = c_fips_out; mode_in = 2'b01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !all_phase(2); i++) begin
            @(posedge clk); #1;
        end
        check("bp_reach_done", 0, 128'(all_phase(2)), 128'd1);
        in_valid = 1'b1; state_in = c_seq; mode_in = 2'b00;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready", 1, 128'(g_inst[0].in_ready_w), 128'd1);
        check("bp_in_ready", 2, 128'(g_inst[1].in_ready_w), 128'd1);
        check("bp_in_ready", 4, 128'(g_inst[2].in_ready_w), 128'd1);
        check_last("bp_result", c_fips_in);

        // Abort a transfer two column edges in.
        in_valid = 1'b1; state_in = rnd128(); mode_in = 2'b00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_idle(1'b0);
        check_err("err_cleared", 1'b0);
        send(c_c6, 2'b00, 1'b0);       check_last("c6_fwd", c_c6);

        for (int t = 0; t < 40; t++) begin
            send(rnd128(), 2'($urandom % 4), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
